// File: rtl/gearbox_ser_if.sv
// gearbox_ser_if: word handshake, serial output and underflow status bundle for gearbox_ser.
interface gearbox_ser_if #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 2
);
    logic [IN_WIDTH-1:0]  din;
    logic                 din_valid;
    logic                 din_ready;
    logic                 msb_first;
    logic [OUT_WIDTH-1:0] dout;
    logic                 dout_valid;
    logic                 underflow;
    logic                 underflow_clr;
    modport master (
        output din, din_valid, msb_first, underflow_clr,
        input  din_ready, dout, dout_valid, underflow
    );
    modport slave (
        input  din, din_valid, msb_first, underflow_clr,
        output din_ready, dout, dout_valid, underflow
    );
endinterface

// File: rtl/gearbox_ser.sv
// gearbox_ser: IN_WIDTH->OUT_WIDTH gapless serializer with one-word holding buffer and sticky underflow.
// Optional macro GEARBOX_SER_PRBS_EN fills idle cycles with PRBS7 instead of zeros.
module gearbox_ser #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 2
) (
    input logic          clk,
    input logic          rst,
    gearbox_ser_if.slave s
);
    localparam int N  = IN_WIDTH / OUT_WIDTH;
    localparam int BW = N > 1 ? $clog2(N) : 1;
    localparam logic [BW-1:0] LAST = BW'(N - 1);

    typedef enum logic {IDLE, STREAM} state_t;
    state_t r_state, w_state_nxt;

    logic [IN_WIDTH-1:0]  r_sr, r_hr, w_word;
    logic [BW-1:0]        r_beat;
    logic                 r_hr_full, r_chain, r_underflow;
    logic                 w_xfer, w_slot, w_load, w_load_hr, w_hr_in, w_uf_set;
    logic [OUT_WIDTH-1:0] w_fill;

    always_comb begin
        w_word = s.din;
        for (int i = 0; i < IN_WIDTH; i++) w_word[i] = s.msb_first ? s.din[IN_WIDTH-1-i] : s.din[i];
    end

    assign s.din_ready = !r_hr_full && !rst;
    assign w_xfer      = s.din_valid && s.din_ready;
    // A load slot opens when SR is empty or about to emit its final beat.
    assign w_slot      = r_state == IDLE || r_beat == LAST;
    assign w_load_hr   = w_slot && r_hr_full;
    assign w_load      = w_load_hr || (w_slot && w_xfer);
    assign w_hr_in     = w_xfer && !(w_slot && !r_hr_full);
    assign w_uf_set    = r_state == STREAM && w_slot && !w_load && r_chain;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = w_slot ? (w_load ? STREAM : IDLE) : r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr        <= '0;
            r_hr        <= '0;
            r_hr_full   <= 1'b0;
            r_beat      <= '0;
            r_chain     <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_load) begin
                r_sr    <= w_load_hr ? r_hr : w_word;
                r_beat  <= '0;
                r_chain <= r_state == STREAM;
            end else if (!w_slot) begin
                r_sr   <= r_sr >> OUT_WIDTH;
                r_beat <= r_beat + 1'b1;
            end else begin
                r_beat <= '0;
            end
            if (w_hr_in) r_hr <= w_word;
            r_hr_full   <= w_hr_in || (r_hr_full && !w_load_hr);
            r_underflow <= w_uf_set || (r_underflow && !s.underflow_clr);
        end
    end

`ifdef GEARBOX_SER_PRBS_EN
    logic [6:0] r_lfsr, w_lfsr_nxt;
    // x^7+x^6+1; the bit leaving the top of the register is the next one on the line.
    always_comb begin
        w_lfsr_nxt = r_lfsr;
        w_fill     = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            w_fill[i]  = w_lfsr_nxt[6];
            w_lfsr_nxt = {w_lfsr_nxt[5:0], w_lfsr_nxt[6] ^ w_lfsr_nxt[5]};
        end
    end
    always_ff @(posedge clk) begin
        if (rst)                  r_lfsr <= 7'h7F;
        else if (r_state == IDLE) r_lfsr <= w_lfsr_nxt;
    end
`else
    assign w_fill = '0;
`endif

    always_comb begin
        s.dout_valid = r_state == STREAM;
        s.dout       = r_state == STREAM ? r_sr[OUT_WIDTH-1:0] : w_fill;
    end

    assign s.underflow = r_underflow;
endmodule

// File: tb/tb_gearbox_ser.sv
// tb_gearbox_ser: random and directed checks of gearbox_ser (8->2 and 4->4) against a slice-queue model.
// Idle expectations follow GEARBOX_SER_PRBS_EN when it is defined.
`timescale 1ns/1ps
module tb_gearbox_ser;
    localparam int IW = 8, OW = 2, N = IW / OW;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    gearbox_ser_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) a ();
    gearbox_ser_if #(.IN_WIDTH(4), .OUT_WIDTH(4)) b ();
    gearbox_ser #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (.clk(clk), .rst(rst), .s(a));
    gearbox_ser #(.IN_WIDTH(4), .OUT_WIDTH(4)) dut1 (.clk(clk), .rst(rst), .s(b));

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: q holds every slice still to appear on dout, q[0] being the one shown now.
    logic [OW-1:0] q[$];
    int            burst = 0;
    logic          uf = 1'b0;
    logic          prbs[127];
    int            pidx = 0;
    logic [OW-1:0] s_dout;
    logic          s_dv, s_rdy, s_uf;

    function automatic logic [OW-1:0] fill();
        logic [OW-1:0] f = '0;
`ifdef GEARBOX_SER_PRBS_EN
        for (int i = 0; i < OW; i++) f[i] = prbs[(pidx + i) % 127];
`endif
        return f;
    endfunction

    function automatic logic [31:0] rev(input logic [31:0] w, input int width);
        logic [31:0] r = '0;
        for (int i = 0; i < width; i++) r[i] = w[width-1-i];
        return r;
    endfunction

    task automatic step(input logic v, input logic [IW-1:0] d, input logic m, input logic clr,
                        input logic r, output logic xfer);
        logic [IW-1:0] w;
        logic          rdy_exp, idle;
        @(negedge clk);
        rst = r;
        a.din_valid = v;
        a.din = d;
        a.msb_first = m;
        a.underflow_clr = clr;
        #1;
        s_dout = a.dout;
        s_dv   = a.dout_valid;
        s_rdy  = a.din_ready;
        s_uf   = a.underflow;
        rdy_exp = !r && q.size() <= N;
        check("dout_valid", s_dv, q.size() != 0);
        check("dout", s_dout, q.size() != 0 ? q[0] : fill());
        check("din_ready", s_rdy, rdy_exp);
        check("underflow", s_uf, uf);
        xfer = v && rdy_exp;
        w = m ? IW'(rev(d, IW)) : d;
        @(posedge clk);
        if (r) begin
            q.delete();
            burst = 0;
            uf = 1'b0;
            pidx = 0;
        end else begin
            idle = q.size() == 0;
            if (idle) pidx = (pidx + OW) % 127;
            else void'(q.pop_front());
            if (xfer) begin
                burst = idle ? 1 : burst + 1;
                for (int k = 0; k < N; k++) q.push_back(w[k*OW +: OW]);
            end
            uf = (!idle && q.size() == 0 && burst >= 2) || (uf && !clr);
            if (q.size() == 0) burst = 0;
        end
    endtask

    logic          x, hv, hm, pv;
    logic [IW-1:0] hd;
    logic [3:0]    pw;
    logic [1:0]    e_lsb[4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [1:0]    e_msb[4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0]    e_0f[4]  = '{2'b11, 2'b11, 2'b00, 2'b00};
    logic [IW-1:0] words[4] = '{8'h01, 8'hFF, 8'h80, 8'h00};
    logic          bits[140];
    int            wi, vcount, dens;

    initial begin
        for (int i = 0; i < 127; i++) prbs[i] = i < 7 ? 1'b1 : prbs[i-7] ^ prbs[i-6];
        a.din = '0; a.din_valid = 1'b0; a.msb_first = 1'b0; a.underflow_clr = 1'b0;
        b.din = '0; b.din_valid = 1'b0; b.msb_first = 1'b0; b.underflow_clr = 1'b0;
        repeat (2) @(posedge clk);
        step(0, 0, 0, 0, 1, x);
        check("rst_ready", s_rdy, 0);
        step(0, 0, 0, 0, 0, x);
        check("post_rst_ready", s_rdy, 1);
        check("post_rst_valid", s_dv, 0);

        step(1, 8'hB4, 0, 0, 0, x);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0, x);
            check("b4_lsb", s_dout, e_lsb[k]);
            check("b4_lsb_valid", s_dv, 1);
        end
        step(0, 0, 0, 0, 0, x);
        check("b4_lsb_end", s_dv, 0);
        check("b4_lsb_uf", s_uf, 0);

        step(1, 8'hB4, 1, 0, 0, x);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0, x);
            check("b4_msb", s_dout, e_msb[k]);
        end

        wi = 0;
        vcount = 0;
        for (int c = 0; c < 16; c++) begin
            step(wi < 3, words[wi], 0, 0, 0, x);
            if (x) wi++;
            vcount += int'(s_dv);
            if (c >= 5 && c <= 8) check("b2b_ff", s_dout, 2'b11);
            if (c == 2) check("b2b_hr_full_ready", s_rdy, 0);
        end
        check("b2b_valid_cycles", vcount, 12);
        check("b2b_uf_set", s_uf, 1);
        step(0, 0, 0, 1, 0, x);
        step(0, 0, 0, 0, 0, x);
        check("uf_clr", s_uf, 0);

        step(1, 8'hA5, 0, 0, 0, x);
        step(1, 8'h3C, 0, 0, 0, x);
        step(0, 0, 0, 0, 0, x);
        check("mid_hr_full_ready", s_rdy, 0);
        step(0, 0, 0, 0, 1, x);
        step(1, 8'h0F, 0, 0, 0, x);
        check("rst_mid_valid", s_dv, 0);
        check("rst_mid_ready", s_rdy, 1);
`ifndef GEARBOX_SER_PRBS_EN
        check("rst_mid_dout", s_dout, 0);
`endif
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0, x);
            check("w0f", s_dout, e_0f[k]);
        end

        step(0, 0, 0, 0, 1, x);
        for (int c = 0; c < 70; c++) begin
            step(0, 0, 0, 0, 0, x);
            bits[2*c]   = s_dout[0];
            bits[2*c+1] = s_dout[1];
        end
`ifdef GEARBOX_SER_PRBS_EN
        for (int i = 0; i < 7; i++) check("prbs_ones", bits[i], 1);
        check("prbs_bit8", bits[7], 0);
        for (int i = 0; i < 13; i++) check("prbs_period", bits[i+127], bits[i]);
`else
        for (int i = 0; i < 16; i++) check("idle_zero", bits[i], 0);
`endif

        hv = 1'b0; hd = '0; hm = 1'b0; x = 1'b0;
        for (int c = 0; c < 500; c++) begin
            dens = 20 + (c / 100) * 20;
            if (!(hv && !x)) begin
                hv = $urandom_range(0, 99) < dens;
                hd = IW'($urandom);
                hm = 1'($urandom);
            end
            step(hv, hd, hm, $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0, x);
        end
        @(negedge clk);
        rst = 1'b0;
        a.din_valid = 1'b0;

        pv = 1'b0;
        pw = '0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            b.din_valid = c < 30 || $urandom_range(0, 3) != 0;
            b.din = 4'($urandom);
            b.msb_first = 1'($urandom);
            #1;
            check("n1_ready", b.din_ready, 1);
            check("n1_valid", b.dout_valid, pv);
            if (pv) check("n1_dout", b.dout, pw);
            pv = b.din_valid;
            pw = b.msb_first ? 4'(rev(32'(b.din), 4)) : b.din;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
